// File: rtl/types_pkg.sv
// Shared sizing and tag types for the rename stage.
// Holds the default register-file, ROB and checkpoint dimensions and the
// tag typedefs derived from them, so every block agrees on widths.
package types_pkg;

  localparam int ARCH_REGS = 32;
  localparam int PHYS_REGS = 128;
  localparam int ROB_DEPTH = 16;
  localparam int NUM_CKPT  = 4;

  localparam int AREG_W = $clog2(ARCH_REGS);
  localparam int PREG_W = $clog2(PHYS_REGS);
  localparam int ROB_W  = $clog2(ROB_DEPTH);
  localparam int CKPT_W = $clog2(NUM_CKPT);

  typedef logic [AREG_W-1:0] areg_t;
  typedef logic [PREG_W-1:0] preg_t;
  typedef logic [ROB_W-1:0]  rob_tag_t;
  typedef logic [CKPT_W-1:0] ckpt_id_t;

endpackage

// File: rtl/rename_freelist.sv
// Purpose: circular free list of physical registers with a rewindable read pointer.
// Latency: head/empty are combinational from state; push/pop/restore update on the next edge.
// Backpressure: none internally; the caller must not pop while empty.
// Ports: push/push_preg return a register, pop consumes head, restore/restore_ptr
//        rewind r_ptr to a saved value (w_ptr untouched), r_ptr exposed for snapshots.
module rename_freelist #(
  parameter  int PHYS_REGS = types_pkg::PHYS_REGS,
  parameter  int ARCH_REGS = types_pkg::ARCH_REGS,
  localparam int PW        = $clog2(PHYS_REGS),
  localparam int PTRW      = PW + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  logic [PW-1:0]   push_preg,
  input  logic            pop,
  input  logic            restore,
  input  logic [PTRW-1:0] restore_ptr,
  output logic [PW-1:0]   head,
  output logic            empty,
  output logic [PTRW-1:0] r_ptr
);

  logic [PW-1:0]   mem [PHYS_REGS];
  logic [PTRW-1:0] w_ptr;

  // Pointers carry one wrap bit so full and empty are distinguishable.
  assign empty = (r_ptr == w_ptr);
  assign head  = mem[r_ptr[PW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < PHYS_REGS; i++) begin
        mem[i] <= (i < PHYS_REGS - ARCH_REGS) ? PW'(ARCH_REGS + i) : '0;
      end
      w_ptr <= PTRW'(PHYS_REGS - ARCH_REGS);
    end else if (push) begin
      mem[w_ptr[PW-1:0]] <= push_preg;
      w_ptr              <= w_ptr + PTRW'(1);
    end
  end

  // A rewind discards every pop since the snapshot; entries between the
  // restored r_ptr and w_ptr are still intact because w_ptr never laps them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr <= '0;
    end else if (restore) begin
      r_ptr <= restore_ptr;
    end else if (pop) begin
      r_ptr <= r_ptr + PTRW'(1);
    end
  end

endmodule

// File: rtl/rename_ckpt.sv
// Purpose: register rename with map table, free list and branch checkpoints.
// Latency: one cycle from fire to registered rename result.
// Backpressure: ready_in drops on output stall, empty free list, full checkpoints or mispredict.
// Ports: valid_in/ready_in + rs1/rs2/rd/writes_rd/is_branch in; valid_out/ready_out +
//        ps1/ps2/pd_old/pd_new/rob_tag/ckpt_id out; free_* returns registers; resolve_* resolves branches.
module rename_ckpt #(
  parameter  int ARCH_REGS = types_pkg::ARCH_REGS,
  parameter  int PHYS_REGS = types_pkg::PHYS_REGS,
  parameter  int ROB_DEPTH = types_pkg::ROB_DEPTH,
  parameter  int NUM_CKPT  = types_pkg::NUM_CKPT,
  localparam int AW        = $clog2(ARCH_REGS),
  localparam int PW        = $clog2(PHYS_REGS),
  localparam int RW        = $clog2(ROB_DEPTH),
  localparam int CW        = $clog2(NUM_CKPT),
  localparam int PTRW      = PW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          valid_in,
  output logic          ready_in,
  input  logic [AW-1:0] rs1,
  input  logic [AW-1:0] rs2,
  input  logic [AW-1:0] rd,
  input  logic          writes_rd,
  input  logic          is_branch,
  output logic          valid_out,
  input  logic          ready_out,
  output logic [PW-1:0] ps1,
  output logic [PW-1:0] ps2,
  output logic [PW-1:0] pd_old,
  output logic [PW-1:0] pd_new,
  output logic [RW-1:0] rob_tag,
  output logic [CW-1:0] ckpt_id,
  input  logic          free_valid,
  input  logic [PW-1:0] free_preg,
  input  logic          resolve_valid,
  input  logic [CW-1:0] resolve_ckpt,
  input  logic          resolve_mispredict
);

  logic [PW-1:0]   map_q     [ARCH_REGS];
  logic [PW-1:0]   map_next  [ARCH_REGS];
  logic [PW-1:0]   ckpt_map  [NUM_CKPT][ARCH_REGS];
  logic [PTRW-1:0] ckpt_rptr [NUM_CKPT];
  logic [RW-1:0]   ckpt_rob  [NUM_CKPT];
  logic [NUM_CKPT-1:0] ckpt_valid;
  logic [NUM_CKPT-1:0] squash_mask;
  logic [CW-1:0]   ckpt_tail;
  logic [CW-1:0]   ckpt_span;
  logic [CW-1:0]   ckpt_off;
  logic [RW-1:0]   rob_cnt;

  logic            needs_pd, ckpt_full, mispredict_req;
  logic            do_restore, do_release, fire, pop, branch_fire, fl_push;
  logic [PW-1:0]   fl_head;
  logic            fl_empty;
  logic [PTRW-1:0] fl_r_ptr;

  assign needs_pd       = writes_rd && (rd != '0);
  assign ckpt_full      = ckpt_valid[ckpt_tail];
  assign mispredict_req = resolve_valid && resolve_mispredict;
  assign do_restore     = mispredict_req && ckpt_valid[resolve_ckpt];
  assign do_release     = resolve_valid && !resolve_mispredict && ckpt_valid[resolve_ckpt];
  assign fl_push        = free_valid && (free_preg != '0);

  // Any mispredict request blocks rename, even one aimed at a dead slot.
  assign ready_in = (ready_out || !valid_out)
                  && !(needs_pd && fl_empty)
                  && !(is_branch && ckpt_full)
                  && !mispredict_req;

  assign fire        = valid_in && ready_in;
  assign pop         = fire && needs_pd;
  assign branch_fire = fire && is_branch;

  rename_freelist #(
    .PHYS_REGS (PHYS_REGS),
    .ARCH_REGS (ARCH_REGS)
  ) u_freelist (
    .clk         (clk),
    .reset       (reset),
    .push        (fl_push),
    .push_preg   (free_preg),
    .pop         (pop),
    .restore     (do_restore),
    .restore_ptr (ckpt_rptr[resolve_ckpt]),
    .head        (fl_head),
    .empty       (fl_empty),
    .r_ptr       (fl_r_ptr)
  );

  // Map as it will look after this cycle's rename; a branch snapshots this
  // so its own destination survives a rollback to its checkpoint.
  always_comb begin
    for (int i = 0; i < ARCH_REGS; i++) begin
      map_next[i] = map_q[i];
    end
    if (pop) begin
      map_next[rd] = fl_head;
    end
  end

  // Slots from resolve_ckpt up to ckpt_tail-1 in ring order are the
  // mispredicted branch and everything younger. A zero span with a valid
  // target means the ring is full, so every slot goes.
  always_comb begin
    squash_mask = '0;
    ckpt_off    = '0;
    ckpt_span   = ckpt_tail - resolve_ckpt;
    for (int j = 0; j < NUM_CKPT; j++) begin
      ckpt_off = CW'(j) - resolve_ckpt;
      if ((ckpt_off < ckpt_span) || (ckpt_span == '0)) begin
        squash_mask[j] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ARCH_REGS; i++) begin
        map_q[i] <= PW'(i);
      end
    end else if (do_restore) begin
      for (int i = 0; i < ARCH_REGS; i++) begin
        map_q[i] <= ckpt_map[resolve_ckpt][i];
      end
    end else if (fire) begin
      for (int i = 0; i < ARCH_REGS; i++) begin
        map_q[i] <= map_next[i];
      end
    end
  end

  // Snapshot storage needs no reset: a slot is only read while its valid bit is set.
  always_ff @(posedge clk) begin
    if (branch_fire) begin
      for (int i = 0; i < ARCH_REGS; i++) begin
        ckpt_map[ckpt_tail][i] <= map_next[i];
      end
      ckpt_rptr[ckpt_tail] <= fl_r_ptr + PTRW'(pop);
      ckpt_rob[ckpt_tail]  <= rob_cnt + RW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ckpt_valid <= '0;
      ckpt_tail  <= '0;
    end else if (do_restore) begin
      ckpt_valid <= ckpt_valid & ~squash_mask;
      ckpt_tail  <= resolve_ckpt;
    end else begin
      if (do_release) begin
        ckpt_valid[resolve_ckpt] <= 1'b0;
      end
      if (branch_fire) begin
        ckpt_valid[ckpt_tail] <= 1'b1;
        ckpt_tail             <= ckpt_tail + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rob_cnt <= '0;
    end else if (do_restore) begin
      rob_cnt <= ckpt_rob[resolve_ckpt];
    end else if (fire) begin
      rob_cnt <= rob_cnt + RW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_out <= 1'b0;
      ps1       <= '0;
      ps2       <= '0;
      pd_old    <= '0;
      pd_new    <= '0;
      rob_tag   <= '0;
      ckpt_id   <= '0;
    end else if (do_restore) begin
      valid_out <= 1'b0;
    end else if (fire) begin
      valid_out <= 1'b1;
      ps1       <= map_q[rs1];
      ps2       <= map_q[rs2];
      pd_old    <= map_q[rd];
      pd_new    <= pop ? fl_head : '0;
      rob_tag   <= rob_cnt;
      ckpt_id   <= ckpt_tail;
    end else if (ready_out) begin
      valid_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rename_ckpt.sv
// Purpose: self-checking bench for rename_ckpt against a queue-based rename model.
// Latency: model predicts the registered outputs one cycle after each accepted instruction.
// Backpressure: ready_out is driven randomly and held low in a directed stall case.
module tb_rename_ckpt;
  import types_pkg::*;

  localparam int AR = ARCH_REGS;
  localparam int PR = PHYS_REGS;
  localparam int RD = ROB_DEPTH;
  localparam int NC = NUM_CKPT;

  logic     clk = 1'b0;
  logic     reset;
  logic     valid_in, ready_in, writes_rd, is_branch, valid_out, ready_out;
  areg_t    rs1, rs2, rd;
  preg_t    ps1, ps2, pd_old, pd_new, free_preg;
  rob_tag_t rob_tag;
  ckpt_id_t ckpt_id, resolve_ckpt;
  logic     free_valid, resolve_valid, resolve_mispredict;

  always #5 clk = ~clk;

  rename_ckpt dut (
    .clk (clk), .reset (reset), .valid_in (valid_in), .ready_in (ready_in),
    .rs1 (rs1), .rs2 (rs2), .rd (rd), .writes_rd (writes_rd), .is_branch (is_branch),
    .valid_out (valid_out), .ready_out (ready_out),
    .ps1 (ps1), .ps2 (ps2), .pd_old (pd_old), .pd_new (pd_new),
    .rob_tag (rob_tag), .ckpt_id (ckpt_id),
    .free_valid (free_valid), .free_preg (free_preg),
    .resolve_valid (resolve_valid), .resolve_ckpt (resolve_ckpt),
    .resolve_mispredict (resolve_mispredict)
  );

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: map as an int array, free list as a queue, a log of
  // every popped register so a rollback can return them to the head.
  int m_map [AR];
  int m_fl [$];
  int m_pops [$];
  int m_rob, m_seq;
  bit ck_v [NC];
  int ck_map [NC][AR];
  int ck_npop [NC];
  int ck_rob [NC];
  int ck_seq [NC];
  int ck_tail;
  int fr_reg [$];
  int fr_seq [$];
  bit e_vo, e_br;
  int e_ps1, e_ps2, e_pdo, e_pdn, e_rob, e_ck;

  function automatic bit model_rdy();
    bit need;
    need = writes_rd && (rd != '0);
    return (ready_out || !e_vo) && !(need && m_fl.size() == 0)
           && !(is_branch && ck_v[ck_tail]) && !(resolve_valid && resolve_mispredict);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < AR; i++) m_map[i] = i;
    m_fl.delete();
    for (int p = AR; p < PR; p++) m_fl.push_back(p);
    m_pops.delete();
    fr_reg.delete();
    fr_seq.delete();
    m_rob = 0; m_seq = 0; ck_tail = 0;
    for (int j = 0; j < NC; j++) ck_v[j] = 0;
    e_vo = 0; e_br = 0; e_ps1 = 0; e_ps2 = 0; e_pdo = 0; e_pdn = 0; e_rob = 0; e_ck = 0;
  endtask

  task automatic model_step();
    bit need, fire, mis;
    int rc, pd, j;
    need = writes_rd && (rd != '0);
    mis  = resolve_valid && resolve_mispredict;
    fire = valid_in && model_rdy();
    rc   = int'(resolve_ckpt);
    if (free_valid && free_preg != '0) m_fl.push_back(int'(free_preg));
    if (resolve_valid && ck_v[rc]) begin
      if (mis) begin
        for (int i = 0; i < AR; i++) m_map[i] = ck_map[rc][i];
        while (m_pops.size() > ck_npop[rc]) m_fl.push_front(m_pops.pop_back());
        m_rob = ck_rob[rc];
        for (int k = fr_seq.size() - 1; k >= 0; k--) begin
          if (fr_seq[k] >= ck_seq[rc]) begin
            fr_seq.delete(k);
            fr_reg.delete(k);
          end
        end
        j = rc;
        do begin
          ck_v[j] = 0;
          j = (j + 1) % NC;
        end while (j != ck_tail);
        ck_tail = rc;
        e_vo = 0;
      end else begin
        ck_v[rc] = 0;
      end
    end
    if (fire) begin
      e_vo = 1; e_br = is_branch;
      e_ps1 = m_map[rs1]; e_ps2 = m_map[rs2]; e_pdo = m_map[rd];
      e_rob = m_rob; m_rob = (m_rob + 1) % RD;
      e_pdn = 0;
      if (need) begin
        pd = m_fl.pop_front();
        m_pops.push_back(pd);
        fr_reg.push_back(m_map[rd]);
        fr_seq.push_back(m_seq);
        m_map[rd] = pd;
        e_pdn = pd;
      end
      if (is_branch) begin
        for (int i = 0; i < AR; i++) ck_map[ck_tail][i] = m_map[i];
        ck_npop[ck_tail] = m_pops.size();
        ck_rob[ck_tail]  = m_rob;
        ck_seq[ck_tail]  = m_seq + 1;
        ck_v[ck_tail]    = 1;
        e_ck = ck_tail;
        ck_tail = (ck_tail + 1) % NC;
      end
      m_seq++;
    end else if (ready_out) begin
      e_vo = 0;
    end
  endtask

  // One clock: compare on the falling edge, advance the model on the rising edge.
  task automatic cyc();
    @(negedge clk);
    check_eq("ready_in", 32'(ready_in), 32'(model_rdy()));
    check_eq("valid_out", 32'(valid_out), 32'(e_vo));
    if (e_vo) begin
      check_eq("ps1", 32'(ps1), e_ps1);
      check_eq("ps2", 32'(ps2), e_ps2);
      check_eq("pd_old", 32'(pd_old), e_pdo);
      check_eq("pd_new", 32'(pd_new), e_pdn);
      check_eq("rob_tag", 32'(rob_tag), e_rob);
      if (e_br) check_eq("ckpt_id", 32'(ckpt_id), e_ck);
    end
    @(posedge clk);
    if (reset) model_reset();
    else model_step();
    #1;
  endtask

  task automatic idle();
    valid_in = 0; rs1 = '0; rs2 = '0; rd = '0; writes_rd = 0; is_branch = 0;
    ready_out = 1; free_valid = 0; free_preg = '0;
    resolve_valid = 0; resolve_ckpt = '0; resolve_mispredict = 0;
  endtask

  task automatic instr(input int r1, input int r2, input int d, input bit w, input bit br);
    valid_in = 1; rs1 = areg_t'(r1); rs2 = areg_t'(r2); rd = areg_t'(d);
    writes_rd = w; is_branch = br;
  endtask

  task automatic do_reset();
    reset = 1;
    model_reset();
    idle();
    cyc();
    check_eq("rst_valid_out", 32'(valid_out), 0);
    check_eq("rst_pd_new", 32'(pd_new), 0);
    check_eq("rst_rob_tag", 32'(rob_tag), 0);
    check_eq("rst_ps1", 32'(ps1), 0);
    cyc();
    reset = 0;
  endtask

  task automatic rand_drive();
    int oldest, pick;
    int vlist [$];
    idle();
    ready_out = ($urandom_range(0, 9) < 8);
    if ($urandom_range(0, 9) < 7)
      instr($urandom_range(0, AR - 1), $urandom_range(0, AR - 1), $urandom_range(0, AR - 1),
            $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 2);
    // Only registers displaced by instructions older than every live
    // checkpoint may be returned; younger ones could still be rolled back.
    oldest = 32'h7fff_ffff;
    for (int j = 0; j < NC; j++) if (ck_v[j] && ck_seq[j] < oldest) oldest = ck_seq[j];
    if (fr_reg.size() > 0 && fr_seq[0] < oldest && $urandom_range(0, 9) < 4) begin
      free_valid = 1;
      free_preg  = preg_t'(fr_reg.pop_front());
      void'(fr_seq.pop_front());
    end else if ($urandom_range(0, 19) == 0) begin
      free_valid = 1;
      free_preg  = '0;
    end
    if ($urandom_range(0, 9) < 2) begin
      resolve_valid      = 1;
      resolve_mispredict = ($urandom_range(0, 3) == 0);
      for (int j = 0; j < NC; j++) if (ck_v[j]) vlist.push_back(j);
      if (vlist.size() > 0 && $urandom_range(0, 9) < 9) begin
        pick = $urandom_range(0, vlist.size() - 1);
        resolve_ckpt = ckpt_id_t'(vlist[pick]);
      end else begin
        resolve_ckpt = ckpt_id_t'($urandom_range(0, NC - 1));
      end
    end
  endtask

  initial begin
    reset = 1;
    idle();
    model_reset();

    // Two writers to x5 back to back.
    do_reset();
    instr(1, 2, 5, 1, 0); cyc();
    check_eq("add1_pd_new", 32'(pd_new), 32);
    check_eq("add1_pd_old", 32'(pd_old), 5);
    check_eq("add1_rob_tag", 32'(rob_tag), 0);
    instr(5, 5, 5, 1, 0); cyc();
    check_eq("add2_pd_old", 32'(pd_old), 32);
    check_eq("add2_pd_new", 32'(pd_new), 33);
    idle(); cyc();

    // Drain the free list, then recycle one register.
    do_reset();
    for (int i = 0; i < 96; i++) begin
      instr(i % 32, (i + 3) % 32, 1 + (i % 31), 1, 0); cyc();
    end
    instr(1, 2, 9, 1, 0); #1;
    check_eq("fl_empty_stall", 32'(ready_in), 0);
    free_valid = 1; free_preg = preg_t'(7); cyc();
    free_valid = 0; cyc();
    check_eq("recycled_pd_new", 32'(pd_new), 7);
    idle(); cyc();

    // Fill every checkpoint, then free the oldest.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      instr(0, 0, 0, 0, 1); cyc();
      check_eq("br_ckpt_id", 32'(ckpt_id), i);
    end
    instr(0, 0, 0, 0, 1); #1;
    check_eq("ckpt_full_stall", 32'(ready_in), 0);
    instr(3, 4, 7, 1, 0); #1;
    check_eq("nonbr_while_full", 32'(ready_in), 1);
    cyc();
    idle(); resolve_valid = 1; resolve_ckpt = ckpt_id_t'(0); cyc();
    idle(); instr(0, 0, 0, 0, 1); cyc();
    check_eq("br5_ckpt_id", 32'(ckpt_id), 0);
    idle(); cyc();

    // Roll back to a middle checkpoint.
    do_reset();
    instr(1, 2, 0, 0, 1); cyc();
    instr(1, 2, 3, 1, 1); cyc();
    for (int k = 0; k < 3; k++) begin
      instr(3, 4, 3 + k, 1, 0); cyc();
    end
    instr(0, 0, 0, 0, 1); cyc();
    check_eq("br_ck2_id", 32'(ckpt_id), 2);
    idle(); resolve_valid = 1; resolve_ckpt = ckpt_id_t'(1); resolve_mispredict = 1; #1;
    check_eq("misp_blocks_ready", 32'(ready_in), 0);
    cyc();
    check_eq("misp_valid_out", 32'(valid_out), 0);
    idle(); instr(3, 5, 6, 1, 1); cyc();
    check_eq("restored_rob_tag", 32'(rob_tag), 2);
    check_eq("restored_pd_new", 32'(pd_new), 33);
    check_eq("restored_map_x3", 32'(ps1), 32);
    check_eq("restored_map_x5", 32'(ps2), 5);
    check_eq("restored_tail", 32'(ckpt_id), 1);
    instr(0, 0, 0, 0, 1); cyc();
    check_eq("ck2_reusable", 32'(ckpt_id), 2);
    instr(0, 0, 0, 0, 1); cyc();
    instr(0, 0, 0, 0, 1); #1;
    check_eq("ck0_still_live", 32'(ready_in), 0);
    idle(); cyc();

    // Mispredict colliding with a rename and a free push.
    do_reset();
    instr(0, 0, 4, 1, 0); cyc();
    instr(0, 0, 0, 0, 1); cyc();
    instr(0, 0, 6, 1, 0); cyc();
    instr(1, 1, 7, 1, 0);
    resolve_valid = 1; resolve_ckpt = ckpt_id_t'(0); resolve_mispredict = 1;
    free_valid = 1; free_preg = preg_t'(4);
    cyc();
    check_eq("misp_no_fire_vo", 32'(valid_out), 0);
    idle();
    for (int i = 0; i < 96; i++) begin
      instr(0, 0, 1 + (i % 31), 1, 0); cyc();
      if (i == 0)  check_eq("after_misp_first_pd", 32'(pd_new), 33);
      if (i == 95) check_eq("pushed_reg_kept", 32'(pd_new), 4);
    end
    instr(0, 0, 2, 1, 0); #1;
    check_eq("after_misp_drained", 32'(ready_in), 0);
    idle(); cyc();

    // Output stall holds the result and blocks new renames.
    do_reset();
    ready_out = 0;
    instr(2, 3, 8, 1, 0); cyc();
    for (int k = 0; k < 3; k++) begin
      cyc();
      check_eq("stall_valid_out", 32'(valid_out), 1);
      check_eq("stall_pd_new", 32'(pd_new), 32);
      check_eq("stall_rob_tag", 32'(rob_tag), 0);
      check_eq("stall_ready_in", 32'(ready_in), 0);
    end
    ready_out = 1; cyc();
    check_eq("unstall_pd_new", 32'(pd_new), 33);
    check_eq("unstall_rob_tag", 32'(rob_tag), 1);
    idle(); cyc();

    // Random traffic with a reset in the middle.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      if (c == 2000) begin
        do_reset();
        instr(1, 2, 3, 1, 0); #1;
        check_eq("post_reset_ready", 32'(ready_in), 1);
        cyc();
      end
      rand_drive();
      cyc();
    end
    idle(); cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
